// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature digit sequencer:
// FSM state encoding, 7-segment digit table, blank pattern and code ceiling.
package temp_disp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      TENS    = 3'd2,
      UNITS   = 3'd3,
      BLANK   = 3'd4
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] CODE_MAX  = 7'd99;
   localparam logic [6:0] PWM_TOP   = 7'd99;
   localparam int unsigned BCD_STEPS = 7;

   // Index is the decimal digit; bit0 = segment a ... bit6 = segment g.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      return (digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 7-bit value (<= 99) into two BCD
// digits, one add-3/shift step per clock, seven steps after the start strobe.
module bin2bcd_seq
   import temp_disp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       done
);

   logic [6:0] shreg;
   logic [7:0] bcd;
   logic [2:0] step;
   logic       running;
   logic [6:0] shreg_nxt;
   logic [7:0] bcd_nxt;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_comb begin
      {bcd_nxt, shreg_nxt} = {add3(bcd[7:4]), add3(bcd[3:0]), shreg} << 1;
   end

   // done is combinational so the caller can leave its convert state on the
   // same edge that commits the final step.
   assign done  = running && (step == 3'(BCD_STEPS - 1));
   assign tens  = bcd[7:4];
   assign units = bcd[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bcd     <= '0;
         step    <= '0;
         running <= 1'b0;
      end else if (start) begin
         shreg   <= bin;
         bcd     <= '0;
         step    <= '0;
         running <= 1'b1;
      end else if (running) begin
         shreg <= shreg_nxt;
         bcd   <= bcd_nxt;
         step  <= step + 3'd1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/temp_digit_sequencer.sv
// Latches a saturated temperature code, converts it to BCD and cycles a
// single 7-segment digit through tens/units/blank. Optional PWM image of the
// code is built when TEMP_DISP_PWM_EN is defined; otherwise tempsens_pwm is 0.
module temp_digit_sequencer
   import temp_disp_pkg::*;
#(
   parameter int DWELL_LONG  = 5000,
   parameter int DWELL_SHORT = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_quick_transition,
   input  logic       code_valid,
   input  logic [6:0] code,
   output logic       busy,
   output logic [6:0] segments,
   output logic       tempsens_pwm,
   output logic [2:0] state_dbg
);

   localparam int DWELL_MAX = (DWELL_LONG > DWELL_SHORT) ? DWELL_LONG : DWELL_SHORT;
   localparam int CW        = $clog2(DWELL_MAX + 1);

   state_t          state, state_nxt;
   logic [6:0]      code_lat;
   logic [CW-1:0]   dwell_cnt, dwell_lim, dwell_sel;
   logic            in_phase, phase_end;
   logic            conv_start, conv_done;
   logic [3:0]      bcd_tens, bcd_units;

   assign in_phase  = (state == TENS) || (state == UNITS) || (state == BLANK);
   assign phase_end = in_phase && (dwell_cnt == dwell_lim - CW'(1));
   assign dwell_sel = en_quick_transition ? CW'(DWELL_SHORT) : CW'(DWELL_LONG);

   always_comb begin
      state_nxt  = state;
      conv_start = 1'b0;
      case (state)
         IDLE: begin
            if (code_valid) begin
               state_nxt  = CONVERT;
               conv_start = 1'b1;
            end
         end
         CONVERT: begin
            if (conv_done) state_nxt = TENS;
         end
         TENS, UNITS, BLANK: begin
            // A fresh code pre-empts the display loop regardless of dwell.
            if (code_valid) begin
               state_nxt  = CONVERT;
               conv_start = 1'b1;
            end else if (phase_end) begin
               case (state)
                  TENS:    state_nxt = UNITS;
                  UNITS:   state_nxt = BLANK;
                  default: state_nxt = TENS;
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         code_lat  <= '0;
         dwell_cnt <= '0;
         dwell_lim <= '0;
      end else begin
         state <= state_nxt;
         if (conv_start)
            code_lat <= (code > CODE_MAX) ? CODE_MAX : code;
         // Dwell length is frozen at phase entry.
         if (state_nxt != state) begin
            dwell_cnt <= '0;
            dwell_lim <= dwell_sel;
         end else if (in_phase) begin
            dwell_cnt <= dwell_cnt + CW'(1);
         end else begin
            dwell_cnt <= '0;
         end
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   ((code > CODE_MAX) ? CODE_MAX : code),
      .tens  (bcd_tens),
      .units (bcd_units),
      .done  (conv_done)
   );

   always_comb begin
      segments = SEG_BLANK;
      case (state)
         TENS:    segments = (bcd_tens == 4'd0) ? SEG_BLANK : digit_to_seg(bcd_tens);
         UNITS:   segments = digit_to_seg(bcd_units);
         default: segments = SEG_BLANK;
      endcase
   end

   assign busy      = (state == CONVERT);
   assign state_dbg = state;

`ifdef TEMP_DISP_PWM_EN
   logic [6:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         pwm_cnt <= '0;
      else
         pwm_cnt <= (pwm_cnt == PWM_TOP) ? 7'd0 : pwm_cnt + 7'd1;
   end

   assign tempsens_pwm = (pwm_cnt < code_lat);
`else
   assign tempsens_pwm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_digit_sequencer.sv
// Directed bench for temp_digit_sequencer with default dwell parameters.
module tb_temp_digit_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_quick_transition = 1'b0;
   logic       code_valid = 1'b0;
   logic [6:0] code = '0;
   logic       busy;
   logic [6:0] segments;
   logic       tempsens_pwm;
   logic [2:0] state_dbg;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   temp_digit_sequencer dut (
      .clk                 (clk),
      .rst                 (rst),
      .en_quick_transition (en_quick_transition),
      .code_valid          (code_valid),
      .code                (code),
      .busy                (busy),
      .segments            (segments),
      .tempsens_pwm        (tempsens_pwm),
      .state_dbg           (state_dbg)
   );

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   // Captured on the rising edge following the call.
   task automatic strobe(input logic [6:0] c);
      @(negedge clk);
      code_valid = 1'b1;
      code       = c;
      @(posedge clk);
      #1 code_valid = 1'b0;
   endtask

   // Called right after strobe; ends sampling the first display cycle.
   task automatic wait_convert(input string tag);
      int bc = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (busy === 1'b1 && segments === 7'h00) bc++;
      end
      @(negedge clk);
      vectors++;
      if (bc !== 7 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_busy: got %0d busy cycles (busy now %b) expected 7 (busy now 0)", tag, bc, busy);
      end
   endtask

   // Counts consecutive cycles showing pat starting at the current sample.
   task automatic run_len(input logic [6:0] pat, input int limit, output int n);
      n = 0;
      while (segments === pat && n < limit) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst        = 1'b1;
      code_valid = 1'b1;
      code       = 7'd12;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      code_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (segments !== 7'h00) begin miscompares++; $display("FAIL reset_seg: got %h expected 00", segments); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++;
      if (tempsens_pwm !== 1'b0) begin miscompares++; $display("FAIL reset_pwm: got %b expected 0", tempsens_pwm); end
      vectors++;
      if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
   endtask

   task automatic test_quick_47();
      int n;
      en_quick_transition = 1'b1;
      strobe(7'd47);
      wait_convert("q47");
      run_len(7'h66, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL q47_tens: got %0d cycles expected 50", n); end
      run_len(7'h07, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL q47_units: got %0d cycles expected 50", n); end
      run_len(7'h00, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL q47_blank: got %0d cycles expected 50", n); end
      vectors++;
      if (segments !== 7'h66) begin miscompares++; $display("FAIL q47_loop: got %h expected 66", segments); end
   endtask

   task automatic test_leading_zero();
      int n;
      strobe(7'd5);
      wait_convert("c5");
      run_len(7'h00, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL c5_tens: got %0d cycles expected 50", n); end
      run_len(7'h6D, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL c5_units: got %0d cycles expected 50", n); end
      // BLANK followed by blanked TENS reads as 100 dark cycles.
      run_len(7'h00, 300, n);
      vectors++;
      if (n !== 100) begin miscompares++; $display("FAIL c5_dark: got %0d cycles expected 100", n); end
   endtask

   task automatic test_saturate();
      int n;
      strobe(7'd120);
      wait_convert("c120");
      run_len(7'h6F, 300, n);
      vectors++;
      if (n !== 100) begin miscompares++; $display("FAIL c120_99: got %0d cycles expected 100", n); end
      run_len(7'h00, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL c120_blank: got %0d cycles expected 50", n); end
   endtask

   task automatic test_back_to_back();
      int n;
      strobe(7'd47);
      @(negedge clk);
      @(negedge clk);
      strobe(7'd12);
      for (int k = 0; k < 4; k++) @(negedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || segments !== 7'h66) begin
         miscompares++;
         $display("FAIL ignore_conv: got busy %b seg %h expected busy 0 seg 66", busy, segments);
      end
      run_len(7'h66, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL ignore_tens: got %0d cycles expected 50", n); end
      repeat (9) @(negedge clk);
      vectors++;
      if (segments !== 7'h07) begin miscompares++; $display("FAIL mid_units: got %h expected 07", segments); end
      strobe(7'd12);
      wait_convert("abort12");
      run_len(7'h06, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL c12_tens: got %0d cycles expected 50", n); end
      run_len(7'h5B, 200, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL c12_units: got %0d cycles expected 50", n); end
   endtask

   task automatic test_reset_mid();
      int n;
      strobe(7'd47);
      repeat (3) @(negedge clk);
      pulse_reset();
      vectors++;
      if (busy !== 1'b0 || segments !== 7'h00 || tempsens_pwm !== 1'b0 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_conv: got busy %b seg %h pwm %b st %0d expected 0 00 0 0", busy, segments, tempsens_pwm, state_dbg);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (state_dbg !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_conv_hold: got st %0d expected 0", state_dbg); end
      strobe(7'd47);
      wait_convert("rst_units");
      run_len(7'h66, 200, n);
      repeat (5) @(negedge clk);
      pulse_reset();
      vectors++;
      if (busy !== 1'b0 || segments !== 7'h00 || tempsens_pwm !== 1'b0 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_units: got busy %b seg %h pwm %b st %0d expected 0 00 0 0", busy, segments, tempsens_pwm, state_dbg);
      end
      repeat (200) @(negedge clk);
      vectors++;
      if (segments !== 7'h00 || state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_units_hold: got seg %h expected 00", segments); end
   endtask

   task automatic test_dwell_switch();
      int n;
      en_quick_transition = 1'b0;
      strobe(7'd47);
      wait_convert("dwell");
      run_len(7'h66, 100, n);
      en_quick_transition = 1'b1;
      run_len(7'h66, 6000, n);
      vectors++;
      if (n !== 4900) begin miscompares++; $display("FAIL dwell_tens: got %0d cycles expected %0d", n + 100, 5000); end
      run_len(7'h07, 6000, n);
      vectors++;
      if (n !== 50) begin miscompares++; $display("FAIL dwell_units: got %0d cycles expected 50", n); end
   endtask

   task automatic test_pwm();
      int hi;
      strobe(7'd30);
      hi = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (tempsens_pwm === 1'b1) hi++;
      end
      vectors++;
`ifdef TEMP_DISP_PWM_EN
      if (hi !== 60) begin miscompares++; $display("FAIL pwm30: got %0d high expected 60", hi); end
`else
      if (hi !== 0) begin miscompares++; $display("FAIL pwm_off: got %0d high expected 0", hi); end
`endif
      strobe(7'd0);
      hi = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (tempsens_pwm === 1'b1) hi++;
      end
      vectors++;
      if (hi !== 0) begin miscompares++; $display("FAIL pwm0: got %0d high expected 0", hi); end
   endtask

   initial begin
      test_reset();
      test_quick_47();
      test_leading_zero();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      test_dwell_switch();
      test_pwm();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/temp_digit_sequencer.md
TEMP_DIGIT_SEQUENCER -- requirements
Module: temp_digit_sequencer

Interface
REQ-001 Parameter DWELL_LONG, default 5000: clock cycles each display phase is held in normal mode.
REQ-002 Parameter DWELL_SHORT, default 50: clock cycles each display phase is held when en_quick_transition=1.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en_quick_transition  input  1  selects DWELL_SHORT instead of DWELL_LONG.
REQ-006 code_valid  input  1  one-cycle strobe; qualifies code.
REQ-007 code  input  7  unsigned temperature code from the sensor measurement stage.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 segments  output  7  active-high 7-segment drive; bit0=a ... bit6=g.
REQ-010 tempsens_pwm  output  1  duty-cycle image of the latched code (see Configuration).

Function
REQ-011 States SHALL be IDLE, CONVERT, TENS, UNITS, BLANK.
REQ-012 In IDLE, segments SHALL be 0 and busy 0.
REQ-013 code_valid=1 in IDLE, TENS, UNITS or BLANK SHALL latch min(code,99) and enter CONVERT on the next edge.
REQ-014 code_valid while in CONVERT SHALL be ignored.
REQ-015 CONVERT SHALL perform sequential double-dabble binary-to-BCD, one shift/add-3 step per cycle, exactly 7 cycles; busy=1 and segments=0 throughout.
REQ-016 Strobe captured at edge N: busy high cycles N+1..N+7; TENS entered with segments valid from cycle N+8.
REQ-017 Display loop SHALL be TENS -> UNITS -> BLANK -> TENS, repeating until a new code_valid or reset.
REQ-018 Each display phase SHALL last exactly the dwell count selected by en_quick_transition sampled on phase entry; mid-phase changes take effect at the next phase.
REQ-019 TENS SHALL show the tens digit, except tens digit 0 SHALL show blank (0x00); UNITS SHALL always show the units digit; BLANK SHALL show 0x00.
REQ-020 Digit patterns: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F.
REQ-021 A new code_valid during a display phase SHALL abort the phase immediately (dwell counter cleared).
REQ-022 Dwell counter width SHALL be sized from max(DWELL_LONG, DWELL_SHORT); no wrap within a phase.

Reset
REQ-023 rst=1 SHALL force IDLE, latched code 0, BCD registers 0, dwell and PWM counters 0, busy=0, segments=0, tempsens_pwm=0 on the next edge.
REQ-024 rst asserted mid-CONVERT or mid-phase SHALL abort without completing the sequence; code_valid coincident with rst SHALL be ignored.

Configuration
REQ-025 Macro TEMP_DISP_PWM_EN defined: 100-cycle free-running counter 0..99, wrapping 99->0; tempsens_pwm = (counter < latched code); code 0 gives constant 0, code 99 gives 99/100 duty.
REQ-026 Macro undefined: no PWM counter synthesized; tempsens_pwm tied 0.

Structure
REQ-027 Package temp_disp_pkg SHALL hold the state enum, the digit-to-segment constant table, SEG_BLANK, and the saturation limit 99.
REQ-028 Sub-module bin2bcd_seq SHALL implement the 7-step double-dabble (start strobe, 7-bit in, two 4-bit BCD out, done pulse); all other logic stays in temp_digit_sequencer.

Verification
REQ-029 code=47 strobe, en_quick_transition=1 -> busy 7 cycles; segments 0x66 for 50 cycles, 0x07 for 50, 0x00 for 50, then 0x66 again.
REQ-030 code=5 -> TENS phase 0x00, UNITS 0x6D; code=120 -> saturates, TENS 0x6F, UNITS 0x6F.
REQ-031 code_valid=1 with code=12 during CONVERT of 47 -> ignored, display shows 4/7; strobe 12 during UNITS -> immediate CONVERT, then 0x06/0x5B.
REQ-032 rst pulsed mid-CONVERT and mid-UNITS -> next cycle segments=0, busy=0, tempsens_pwm=0, state IDLE until next strobe.
REQ-033 en_quick_transition toggled 0->1 mid-TENS -> TENS lasts 5000 cycles, UNITS lasts 50.
REQ-034 With TEMP_DISP_PWM_EN, code=30 -> tempsens_pwm high exactly 30 of every 100 cycles; code=0 -> always 0; without macro -> always 0.
